// File: rtl/line_plotter_pkg.sv
// Shared definitions for the Bresenham line plotter, the VGA adapter
// instantiation and the top-level controller.
package line_plotter_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Signed width of dx, dy and err; two extra bits give headroom for
    // the sign and for err + dx + dy with 8-bit coordinates.
    localparam int D_W = X_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        DRAW,
        DONE
    } state_t;

endpackage

// File: rtl/line_plotter_if.sv
// Line request / pixel-write bundle between a controller (master) and
// the line plotter (slave).
interface line_plotter_if;
    import line_plotter_pkg::*;

    logic           start;
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y1;
    logic [C_W-1:0] colour_in;
    logic           busy;
    logic           done;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
    logic           plot;

    modport master (
        output start, x0, y0, x1, y1, colour_in,
        input  busy, done, x, y, colour, plot
    );

    modport slave (
        input  start, x0, y0, x1, y1, colour_in,
        output busy, done, x, y, colour, plot
    );

endinterface

// File: rtl/line_plotter_bresenham_step.sv
// One Bresenham iteration: given the current point and error term,
// produce the next point and error term. Purely combinational.
module bresenham_step
    import line_plotter_pkg::*;
(
    input  logic signed [D_W-1:0] err,
    input  logic signed [D_W-1:0] dx,
    input  logic signed [D_W-1:0] dy,
    input  logic                  sx_neg,
    input  logic                  sy_neg,
    input  logic        [X_W-1:0] cx,
    input  logic        [Y_W-1:0] cy,
    output logic signed [D_W-1:0] err_next,
    output logic        [X_W-1:0] cx_next,
    output logic        [Y_W-1:0] cy_next
);

    logic signed [D_W:0] e2;
    logic signed [D_W:0] dx_ext;
    logic signed [D_W:0] dy_ext;
    logic                step_x;
    logic                step_y;

    // Decide which axes advance this pixel and apply both updates together.
    always_comb begin
        e2       = {err, 1'b0};
        dx_ext   = {dx[D_W-1], dx};
        dy_ext   = {dy[D_W-1], dy};
        step_x   = (e2 >= dy_ext);
        step_y   = (e2 <= dx_ext);
        err_next = err;
        cx_next  = cx;
        cy_next  = cy;
        if (step_x) begin
            err_next = err_next + dy;
            cx_next  = sx_neg ? (cx - X_W'(1)) : (cx + X_W'(1));
        end
        if (step_y) begin
            err_next = err_next + dx;
            cy_next  = sy_neg ? (cy - Y_W'(1)) : (cy + Y_W'(1));
        end
    end

endmodule

// File: rtl/line_plotter.sv
// Bresenham line-drawing engine feeding the VGA adapter pixel-write port.
// One pixel per clock; off-screen pixels are walked with plot held low.
module line_plotter
    import line_plotter_pkg::*;
(
    input logic           CLOCK_50,
    input logic           reset,
    line_plotter_if.slave bus
);

    localparam logic [X_W-1:0] SCREEN_W_X = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0] SCREEN_H_Y = Y_W'(SCREEN_H);

    state_t                state_q, state_d;
    logic        [X_W-1:0] x0_q, x0_d, x1_q, x1_d;
    logic        [Y_W-1:0] y0_q, y0_d, y1_q, y1_d;
    logic        [C_W-1:0] line_colour_q, line_colour_d;
    logic signed [D_W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                  sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic        [X_W-1:0] cx_q, cx_d;
    logic        [Y_W-1:0] cy_q, cy_d;
    logic        [X_W-1:0] x_q, x_d;
    logic        [Y_W-1:0] y_q, y_d;
    logic        [C_W-1:0] colour_q, colour_d;
    logic                  plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    logic signed [D_W-1:0] x_diff, y_diff, dx_abs, dy_neg;
    logic signed [D_W-1:0] err_step;
    logic        [X_W-1:0] cx_step;
    logic        [Y_W-1:0] cy_step;

    bresenham_step u_step (
        .err      (err_q),
        .dx       (dx_q),
        .dy       (dy_q),
        .sx_neg   (sx_neg_q),
        .sy_neg   (sy_neg_q),
        .cx       (cx_q),
        .cy       (cy_q),
        .err_next (err_step),
        .cx_next  (cx_step),
        .cy_next  (cy_step)
    );

    // Next-state, datapath and registered-output logic for the request FSM.
    always_comb begin
        state_d       = state_q;
        x0_d          = x0_q;
        y0_d          = y0_q;
        x1_d          = x1_q;
        y1_d          = y1_q;
        line_colour_d = line_colour_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        err_d         = err_q;
        sx_neg_d      = sx_neg_q;
        sy_neg_d      = sy_neg_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        x_d           = x_q;
        y_d           = y_q;
        colour_d      = colour_q;
        plot_d        = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        x_diff        = $signed({2'b00, x1_q}) - $signed({2'b00, x0_q});
        y_diff        = $signed({{(D_W-Y_W){1'b0}}, y1_q}) - $signed({{(D_W-Y_W){1'b0}}, y0_q});
        dx_abs        = (x_diff < 0) ? -x_diff : x_diff;
        dy_neg        = (y_diff < 0) ? y_diff : -y_diff;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x0_d          = bus.x0;
                    y0_d          = bus.y0;
                    x1_d          = bus.x1;
                    y1_d          = bus.y1;
                    line_colour_d = bus.colour_in;
                    busy_d        = 1'b1;
                    state_d       = INIT;
                end
            end
            INIT: begin
                dx_d     = dx_abs;
                dy_d     = dy_neg;
                err_d    = dx_abs + dy_neg;
                sx_neg_d = !(x0_q < x1_q);
                sy_neg_d = !(y0_q < y1_q);
                cx_d     = x0_q;
                cy_d     = y0_q;
                busy_d   = 1'b1;
                state_d  = DRAW;
            end
            DRAW: begin
                x_d      = cx_q;
                y_d      = cy_q;
                colour_d = line_colour_q;
                plot_d   = (cx_q < SCREEN_W_X) && (cy_q < SCREEN_H_Y);
                busy_d   = 1'b1;
                if ((cx_q == x1_q) && (cy_q == y1_q)) begin
                    state_d = DONE;
                end else begin
                    err_d = err_step;
                    cx_d  = cx_step;
                    cy_d  = cy_step;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, all cleared by synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= IDLE;
            x0_q          <= '0;
            y0_q          <= '0;
            x1_q          <= '0;
            y1_q          <= '0;
            line_colour_q <= '0;
            dx_q          <= '0;
            dy_q          <= '0;
            err_q         <= '0;
            sx_neg_q      <= 1'b0;
            sy_neg_q      <= 1'b0;
            cx_q          <= '0;
            cy_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            colour_q      <= '0;
            plot_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            x0_q          <= x0_d;
            y0_q          <= y0_d;
            x1_q          <= x1_d;
            y1_q          <= y1_d;
            line_colour_q <= line_colour_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            err_q         <= err_d;
            sx_neg_q      <= sx_neg_d;
            sy_neg_q      <= sy_neg_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            x_q           <= x_d;
            y_q           <= y_d;
            colour_q      <= colour_d;
            plot_q        <= plot_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;

endmodule

// File: tb/tb_line_plotter.sv
// Directed testbench for line_plotter: hand-computed pixel sequences,
// handshake timing, clipping, ignored restarts and mid-line reset.
module tb_line_plotter;

    logic clk = 1'b0;
    logic reset;
    int   assertions_evaluated = 0;
    int   assertion_failures   = 0;

    line_plotter_if lp_if ();

    line_plotter dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (lp_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions_evaluated++;
        assert (observed === expected) else begin
            assertion_failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present a request, strobe start for one edge, then step through INIT.
    task automatic applyStimulus(input int ax0, input int ay0, input int ax1, input int ay1, input int acol);
        lp_if.x0        = 8'(ax0);
        lp_if.y0        = 7'(ay0);
        lp_if.x1        = 8'(ax1);
        lp_if.y1        = 7'(ay1);
        lp_if.colour_in = 3'(acol);
        lp_if.start     = 1'b1;
        tick();
        lp_if.start = 1'b0;
        checkOutput("busy after accept", 32'(lp_if.busy), 1);
        checkOutput("plot after accept", 32'(lp_if.plot), 0);
        tick();
        checkOutput("busy before first pixel", 32'(lp_if.busy), 1);
        checkOutput("plot before first pixel", 32'(lp_if.plot), 0);
    endtask

    task automatic expectPixel(input string tag, input int ex, input int ey, input int ep, input int ec);
        tick();
        checkOutput({tag, " x"},      32'(lp_if.x),      32'(ex));
        checkOutput({tag, " y"},      32'(lp_if.y),      32'(ey));
        checkOutput({tag, " plot"},   32'(lp_if.plot),   32'(ep));
        checkOutput({tag, " colour"}, 32'(lp_if.colour), 32'(ec));
        checkOutput({tag, " busy"},   32'(lp_if.busy),   1);
        checkOutput({tag, " done"},   32'(lp_if.done),   0);
    endtask

    task automatic expectDone(input string tag);
        tick();
        checkOutput({tag, " done pulse"}, 32'(lp_if.done), 1);
        checkOutput({tag, " done plot"},  32'(lp_if.plot), 0);
        checkOutput({tag, " done busy"},  32'(lp_if.busy), 0);
        lp_if.start = 1'b0;
        tick();
        checkOutput({tag, " done falls"}, 32'(lp_if.done), 0);
        checkOutput({tag, " idle busy"},  32'(lp_if.busy), 0);
    endtask

    initial begin
        reset           = 1'b1;
        lp_if.start     = 1'b0;
        lp_if.x0        = '0;
        lp_if.y0        = '0;
        lp_if.x1        = '0;
        lp_if.y1        = '0;
        lp_if.colour_in = '0;
        tick();
        tick();
        checkOutput("reset x",      32'(lp_if.x),      0);
        checkOutput("reset y",      32'(lp_if.y),      0);
        checkOutput("reset colour", 32'(lp_if.colour), 0);
        checkOutput("reset plot",   32'(lp_if.plot),   0);
        checkOutput("reset busy",   32'(lp_if.busy),   0);
        checkOutput("reset done",   32'(lp_if.done),   0);
        reset = 1'b0;
        tick();
        checkOutput("idle busy", 32'(lp_if.busy), 0);

        $display("[TB] horizontal (0,0)->(3,0)");
        applyStimulus(0, 0, 3, 0, 4);
        expectPixel("h0", 0, 0, 1, 4);
        expectPixel("h1", 1, 0, 1, 4);
        expectPixel("h2", 2, 0, 1, 4);
        expectPixel("h3", 3, 0, 1, 4);
        expectDone("h");
        checkOutput("hold x after line", 32'(lp_if.x), 3);

        $display("[TB] steep (5,5)->(6,9)");
        applyStimulus(5, 5, 6, 9, 1);
        expectPixel("s0", 5, 5, 1, 1);
        expectPixel("s1", 5, 6, 1, 1);
        expectPixel("s2", 6, 7, 1, 1);
        expectPixel("s3", 6, 8, 1, 1);
        expectPixel("s4", 6, 9, 1, 1);
        expectDone("s");

        $display("[TB] reverse (3,2)->(0,2) and (4,4)->(0,0)");
        applyStimulus(3, 2, 0, 2, 2);
        expectPixel("r0", 3, 2, 1, 2);
        expectPixel("r1", 2, 2, 1, 2);
        expectPixel("r2", 1, 2, 1, 2);
        expectPixel("r3", 0, 2, 1, 2);
        expectDone("r");
        applyStimulus(4, 4, 0, 0, 7);
        expectPixel("d0", 4, 4, 1, 7);
        expectPixel("d1", 3, 3, 1, 7);
        expectPixel("d2", 2, 2, 1, 7);
        expectPixel("d3", 1, 1, 1, 7);
        expectPixel("d4", 0, 0, 1, 7);
        expectDone("d");

        $display("[TB] degenerate and clipped lines");
        applyStimulus(10, 10, 10, 10, 5);
        expectPixel("g0", 10, 10, 1, 5);
        expectDone("g");
        applyStimulus(158, 119, 161, 119, 6);
        expectPixel("c0", 158, 119, 1, 6);
        expectPixel("c1", 159, 119, 1, 6);
        expectPixel("c2", 160, 119, 0, 6);
        expectPixel("c3", 161, 119, 0, 6);
        expectDone("c");

        $display("[TB] start while busy is ignored");
        applyStimulus(20, 30, 23, 30, 3);
        expectPixel("i0", 20, 30, 1, 3);
        lp_if.x0        = 8'd50;
        lp_if.y0        = 7'd60;
        lp_if.x1        = 8'd52;
        lp_if.y1        = 7'd61;
        lp_if.colour_in = 3'd1;
        lp_if.start     = 1'b1;
        expectPixel("i1", 21, 30, 1, 3);
        expectPixel("i2", 22, 30, 1, 3);
        expectPixel("i3", 23, 30, 1, 3);
        expectDone("i");

        $display("[TB] reset mid-line");
        applyStimulus(0, 0, 9, 0, 2);
        expectPixel("m0", 0, 0, 1, 2);
        expectPixel("m1", 1, 0, 1, 2);
        expectPixel("m2", 2, 0, 1, 2);
        reset = 1'b1;
        tick();
        checkOutput("mid reset plot", 32'(lp_if.plot), 0);
        checkOutput("mid reset busy", 32'(lp_if.busy), 0);
        checkOutput("mid reset done", 32'(lp_if.done), 0);
        reset = 1'b0;
        tick();
        checkOutput("post reset done", 32'(lp_if.done), 0);
        checkOutput("post reset busy", 32'(lp_if.busy), 0);
        tick();
        checkOutput("post reset no late done", 32'(lp_if.done), 0);
        checkOutput("post reset plot", 32'(lp_if.plot), 0);

        $display("[TB] new line after reset (7,3)->(7,5)");
        applyStimulus(7, 3, 7, 5, 5);
        expectPixel("v0", 7, 3, 1, 5);
        expectPixel("v1", 7, 4, 1, 5);
        expectPixel("v2", 7, 5, 1, 5);
        expectDone("v");

        $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, assertion_failures);
        $finish;
    end

endmodule
